// File: rtl/clk_period_meter.sv
// Measures the period and high time of an asynchronous clock in clk_i cycles.
// Optional CLK_PERIOD_METER_CHANGE_DET_EN adds a changed_o pulse on period change.
//
// state    | meaning
// ---------+--------------------------------------------------------------
// ST_IDLE  | counters held at 0, waiting for an enabled edge to arm
// ST_ARMED | counting cycles since the last edge, reporting on each edge

module clk_period_meter #(
    parameter int width_p       = 16,
    parameter int sync_stages_p = 2
) (
    input  logic               clk_i,
    input  logic               reset_i,
    input  logic               en_i,
    input  logic               sample_i,
    output logic               v_o,
    input  logic               ready_i,
    output logic [width_p-1:0] period_o,
    output logic [width_p-1:0] high_o,
    output logic               timeout_o,
    output logic               dropped_o
`ifdef CLK_PERIOD_METER_CHANGE_DET_EN
    ,
    output logic               changed_o
`endif
);

    localparam int stages_lp = (sync_stages_p < 2) ? 2 : sync_stages_p;
    localparam logic [width_p-1:0] one_lp  = {{(width_p-1){1'b0}}, 1'b1};
    localparam logic [width_p-1:0] max_lp  = {width_p{1'b1}};
    localparam logic [width_p-1:0] last_lp = max_lp - one_lp;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_ARMED = 1'b1
    } state_t;

    state_t               state_r, state_n;
    logic [stages_lp-1:0] sync_r;
    logic                 prev_r;
    logic                 lvl;
    logic                 rise;
    logic [width_p-1:0]   cnt_r, cnt_n;
    logic [width_p-1:0]   hcnt_r, hcnt_n;
    logic                 meas_v;
    logic [width_p-1:0]   meas_period;
    logic                 timeout_set;
    logic                 load;

    assign lvl  = sync_r[stages_lp-1];
    assign rise = lvl & ~prev_r;

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            sync_r <= '0;
            prev_r <= 1'b0;
        end else begin
            sync_r <= {sync_r[stages_lp-2:0], sample_i};
            prev_r <= lvl;
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_r <= ST_IDLE;
            cnt_r   <= '0;
            hcnt_r  <= '0;
        end else begin
            state_r <= state_n;
            cnt_r   <= cnt_n;
            hcnt_r  <= hcnt_n;
        end
    end

    // The edge cycle itself is counted as high, so a new period starts with hcnt = 1.
    always_comb begin
        state_n     = state_r;
        cnt_n       = cnt_r;
        hcnt_n      = hcnt_r;
        meas_v      = 1'b0;
        timeout_set = 1'b0;
        meas_period = cnt_r + one_lp;
        case (state_r)
            ST_IDLE: begin
                cnt_n  = '0;
                hcnt_n = '0;
                if (en_i && rise) begin
                    hcnt_n  = one_lp;
                    state_n = ST_ARMED;
                end
            end
            ST_ARMED: begin
                if (!en_i) begin
                    state_n = ST_IDLE;
                    cnt_n   = '0;
                    hcnt_n  = '0;
                end else if (rise) begin
                    meas_v = 1'b1;
                    cnt_n  = '0;
                    hcnt_n = one_lp;
                end else if (cnt_r == last_lp) begin
                    // Next count would saturate: no edge within 2^width_p-1 cycles.
                    timeout_set = 1'b1;
                    state_n     = ST_IDLE;
                    cnt_n       = '0;
                    hcnt_n      = '0;
                end else begin
                    cnt_n  = (cnt_r == max_lp) ? cnt_r : cnt_r + one_lp;
                    hcnt_n = (lvl && (hcnt_r != max_lp)) ? hcnt_r + one_lp : hcnt_r;
                end
            end
            default: begin
                state_n = ST_IDLE;
                cnt_n   = '0;
                hcnt_n  = '0;
            end
        endcase
    end

    assign load = meas_v & (~v_o | ready_i);

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            v_o       <= 1'b0;
            period_o  <= '0;
            high_o    <= '0;
            timeout_o <= 1'b0;
            dropped_o <= 1'b0;
        end else begin
            if (load) begin
                v_o      <= 1'b1;
                period_o <= meas_period;
                high_o   <= hcnt_r;
            end else if (v_o && ready_i) begin
                v_o <= 1'b0;
            end
            if (meas_v && v_o && !ready_i) begin
                dropped_o <= 1'b1;
            end
            if (timeout_set) begin
                timeout_o <= 1'b1;
            end
        end
    end

`ifdef CLK_PERIOD_METER_CHANGE_DET_EN
    logic [width_p-1:0] last_period_r;

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            last_period_r <= '0;
            changed_o     <= 1'b0;
        end else if (load) begin
            last_period_r <= meas_period;
            changed_o     <= (meas_period != last_period_r);
        end else begin
            changed_o <= 1'b0;
        end
    end
`endif

endmodule

// File: tb/tb_clk_period_meter.sv
// Randomized bench for clk_period_meter; reports are predicted from the sampled
// waveform by counting cycles and high cycles between rising edges.

module tb_clk_period_meter;

    localparam int W = 8;
    localparam int S = 2;

    logic         clk_i;
    logic         reset_i;
    logic         en_i;
    logic         sample_i;
    logic         v_o;
    logic         ready_i;
    logic [W-1:0] period_o;
    logic [W-1:0] high_o;
    logic         timeout_o;
    logic         dropped_o;
`ifdef CLK_PERIOD_METER_CHANGE_DET_EN
    logic         changed_o;
`endif

    clk_period_meter #(.width_p(W), .sync_stages_p(S)) dut (
        .clk_i     (clk_i),
        .reset_i   (reset_i),
        .en_i      (en_i),
        .sample_i  (sample_i),
        .v_o       (v_o),
        .ready_i   (ready_i),
        .period_o  (period_o),
        .high_o    (high_o),
        .timeout_o (timeout_o),
        .dropped_o (dropped_o)
`ifdef CLK_PERIOD_METER_CHANGE_DET_EN
        ,
        .changed_o (changed_o)
`endif
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    typedef struct {
        int per;
        int hi;
    } rep_t;

    rep_t exp_q[$];
    int   n_vec  = 0;
    int   n_miss = 0;
    int   cyc    = 0;

    bit   armed_m = 1'b0;
    bit   last_m  = 1'b0;
    int   cs_m    = 0;
    int   ones_m  = 0;
    int   last_per_m = 0;
    bit   v_prev_m   = 1'b0;
    bit   rdy_prev_m = 1'b0;

    task automatic check(input string tag, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_miss++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    // One clk_i cycle of the monitored clock, plus the edge-to-edge model.
    task automatic drive_cycle(input bit b);
        rep_t r;
        @(posedge clk_i);
        #1;
        cyc++;
        sample_i = b;
        if (b && !last_m) begin
            if (armed_m) begin
                r.per = cs_m;
                r.hi  = ones_m;
                exp_q.push_back(r);
            end
            armed_m = 1'b1;
            cs_m    = 0;
            ones_m  = 0;
        end else if (armed_m && cs_m == (1 << W) - 1) begin
            armed_m = 1'b0;
        end
        cs_m++;
        ones_m += int'(b);
        last_m = b;
    endtask

    task automatic drive_pulse(input int h, input int l);
        repeat (h) drive_cycle(1'b1);
        repeat (l) drive_cycle(1'b0);
    endtask

    task automatic drain(input string tag);
        repeat (10) drive_cycle(1'b0);
        check(tag, exp_q.size(), 0);
    endtask

    task automatic model_reset();
        exp_q.delete();
        armed_m    = 1'b0;
        last_m     = 1'b0;
        last_per_m = 0;
    endtask

    always @(negedge clk_i) begin
        rep_t r;
        if (!reset_i && v_o) begin
`ifdef CLK_PERIOD_METER_CHANGE_DET_EN
            if (!v_prev_m || rdy_prev_m) begin
                if (exp_q.size() > 0) begin
                    check("changed_fresh", int'(changed_o), int'(exp_q[0].per != last_per_m));
                    last_per_m = exp_q[0].per;
                end
            end else begin
                check("changed_held", int'(changed_o), 0);
            end
`endif
            if (ready_i) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_report", int'(period_o), -1);
                end else begin
                    r = exp_q.pop_front();
                    check("period", int'(period_o), r.per);
                    check("high", int'(high_o), r.hi);
                end
            end
        end
        v_prev_m   = v_o;
        rdy_prev_m = ready_i;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int t_rise;
        reset_i  = 1'b1;
        en_i     = 1'b0;
        sample_i = 1'b0;
        ready_i  = 1'b1;
        repeat (4) @(posedge clk_i);
        #1;
        check("rst_v", int'(v_o), 0);
        check("rst_period", int'(period_o), 0);
        check("rst_high", int'(high_o), 0);
        check("rst_timeout", int'(timeout_o), 0);
        check("rst_dropped", int'(dropped_o), 0);
        reset_i = 1'b0;
        en_i    = 1'b1;

        repeat (12) drive_pulse(4, 4);
        drain("drain_4_4");
        check("timeout_4_4", int'(timeout_o), 0);
        check("dropped_4_4", int'(dropped_o), 0);

        repeat (10) drive_pulse(1, 2);
        repeat (8) drive_pulse(5, 5);
        drain("drain_div3_5_5");

        repeat (30) drive_pulse($urandom_range(1, 12), $urandom_range(1, 12));
        drain("drain_random");

        // Hold off the consumer across three 8-cycle reports.
        repeat (4) drive_cycle(1'b1);
        drive_cycle(1'b0);
        ready_i = 1'b0;
        repeat (3) drive_cycle(1'b0);
        repeat (3) drive_pulse(4, 4);
        repeat (6) drive_cycle(1'b0);
        check("held_v", int'(v_o), 1);
        check("held_period", int'(period_o), 8);
        check("held_high", int'(high_o), 4);
        check("held_dropped", int'(dropped_o), 1);
        while (exp_q.size() > 1) void'(exp_q.pop_back());
        ready_i = 1'b1;
        drive_cycle(1'b0);
        check("accept_v_drop", int'(v_o), 0);
        repeat (3) drive_pulse(4, 4);
        drain("drain_after_hold");
        check("dropped_sticky", int'(dropped_o), 1);

        // Timeout after 2^W-1 cycles without an edge.
        drive_cycle(1'b1);
        t_rise = cyc;
        repeat (2) drive_cycle(1'b1);
        while (cyc < t_rise + S + 255) drive_cycle(1'b0);
        check("timeout_early", int'(timeout_o), 0);
        drive_cycle(1'b0);
        check("timeout_set", int'(timeout_o), 1);
        repeat (5) drive_pulse(4, 4);
        drain("drain_after_timeout");
        check("timeout_sticky", int'(timeout_o), 1);

        // Synchronous reset with a report pending.
        ready_i = 1'b0;
        drive_pulse(4, 4);
        repeat (2) drive_cycle(1'b0);
        check("pre_reset_v", int'(v_o), 1);
        reset_i = 1'b1;
        drive_cycle(1'b0);
        check("mid_rst_v", int'(v_o), 0);
        check("mid_rst_period", int'(period_o), 0);
        check("mid_rst_high", int'(high_o), 0);
        check("mid_rst_timeout", int'(timeout_o), 0);
        check("mid_rst_dropped", int'(dropped_o), 0);
        reset_i = 1'b0;
        model_reset();
        ready_i = 1'b1;
        repeat (4) drive_pulse(4, 4);
        repeat (6) drive_pulse(3 + 3 * $urandom_range(0, 1), $urandom_range(2, 9));
        drain("drain_after_reset");
        check("final_timeout", int'(timeout_o), 0);
        check("final_dropped", int'(dropped_o), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
